// File: rtl/dm_pkg.sv
// Shared types for the P7 data-side wait-state memory.
//   dm_state_e : controller states
//   dm_trace_t : one write-trace record {pc, addr, data}
//   merge()    : byte-lane merge of write data into an existing word
package dm_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } dm_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } dm_trace_t;

   localparam int unsigned TRACE_W = $bits(dm_trace_t);

   // Replace each enabled byte lane of old_w with the matching lane of wdata.
   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] wdata,
                                                input logic [BE_W-1:0]   byteen);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(BE_W); i++) begin
         if (byteen[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_trace_fifo.sv
// Synchronous write-trace FIFO with sticky overflow flag.
//   clk, reset : clock, synchronous active-high reset (empties FIFO, clears ovf)
//   i_push     : push i_data; dropped (and o_ovf set) when full with no pop
//   i_pop      : pop head entry when non-empty
//   o_data     : head entry, read combinationally from storage
//   o_valid    : FIFO non-empty
//   o_ovf      : sticky, a push was dropped
module dm_trace_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 96
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_ovf
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_ovf;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign w_pop   = i_pop & ~w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push  = i_push & (~w_full | w_pop);

   // Storage needs no reset; contents are only visible when counted valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
         if (i_push & ~w_push) r_ovf <= 1'b1;
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_valid = ~w_empty;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/dm_wait_ram.sv
// Word-organised data memory for the P7 data-side bus, with byte-enable
// read-modify-write, configurable wait states, post-reset clear and a
// write-trace FIFO.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (accepted when both high)
//   m_data_addr       : byte address (bits [1:0] ignored)
//   m_data_byteen     : byte enables, 0 = read
//   m_data_wdata      : write data, lane aligned
//   m_inst_addr       : issuing PC, recorded in trace only
//   resp_valid        : one-cycle completion pulse
//   m_data_rdata, oor : response word and out-of-range flag
//   trace_*           : head of the write-trace FIFO, popped by trace_ready
//   trace_ovf         : sticky, a trace entry was dropped
module dm_wait_ram
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned TRACE_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] m_data_addr,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_data_wdata,
   input  logic [31:0] m_inst_addr,
   output logic        resp_valid,
   output logic [31:0] m_data_rdata,
   output logic        oor,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [31:0] trace_pc,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data,
   output logic        trace_ovf
);

   localparam int unsigned DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [3:0]        WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [31:0]       r_mem [DEPTH];
   dm_state_e         r_state;
   dm_state_e         w_next;
   logic [ADDR_W-1:0] r_clr_idx;
   logic [3:0]        r_wait_cnt;
   logic [31:0]       r_lat_rdata;
   logic              r_lat_oor;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic [31:0]       r_rdata;
   logic              r_oor;

   logic [31:0]       w_rel;
   logic              w_in_range;
   logic [ADDR_W-1:0] w_off;
   logic [31:0]       w_old;
   logic [31:0]       w_merged;
   logic              w_is_wr;
   logic              w_accept;
   logic [31:0]       w_acc_rdata;
   logic              w_push;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_idx;
   logic [31:0]       w_mem_wd;
   dm_trace_t         w_push_entry;
   dm_trace_t         w_head;
   logic [TRACE_W-1:0] w_head_bits;

   // Address decode: below-base addresses wrap to huge offsets and fall out of range.
   assign w_rel       = m_data_addr - BASE_ADDR;
   assign w_in_range  = ((w_rel >> (ADDR_W + 2)) == 32'd0);
   assign w_off       = w_rel[ADDR_W+1:2];
   assign w_old       = r_mem[w_off];
   assign w_is_wr     = |m_data_byteen;
   assign w_merged    = merge(w_old, m_data_wdata, m_data_byteen);
   assign w_accept    = req_valid & r_req_ready & ~reset;
   assign w_acc_rdata = !w_in_range ? 32'd0 : (w_is_wr ? w_merged : w_old);
   assign w_push      = w_accept & w_is_wr & w_in_range;

   // Single memory write port shared by the clear sequence and request writes.
   assign w_mem_we  = ~reset & ((r_state == ST_CLEAR) | w_push);
   assign w_mem_idx = (r_state == ST_CLEAR) ? r_clr_idx : w_off;
   assign w_mem_wd  = (r_state == ST_CLEAR) ? 32'd0 : w_merged;

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wd;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_CLEAR;
      else       r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_CLEAR: if (r_clr_idx == LAST_IDX) w_next = ST_IDLE;
         ST_IDLE:  if (w_accept) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
         ST_WAIT:  if (r_wait_cnt == 4'd0) w_next = ST_RESP;
         ST_RESP:  w_next = ST_IDLE;
         default:  w_next = ST_CLEAR;
      endcase
   end

   // Datapath and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clr_idx    <= '0;
         r_wait_cnt   <= 4'd0;
         r_lat_rdata  <= 32'd0;
         r_lat_oor    <= 1'b0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_rdata      <= 32'd0;
         r_oor        <= 1'b0;
      end else begin
         r_req_ready  <= (w_next == ST_IDLE);
         r_resp_valid <= (w_next == ST_RESP);
         if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + ADDR_W'(1);
         if (w_accept) begin
            r_wait_cnt  <= WAIT_LOAD;
            r_lat_rdata <= w_acc_rdata;
            r_lat_oor   <= ~w_in_range;
         end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
         end
         // With no wait states the response is loaded straight off the acceptance edge.
         if (w_next == ST_RESP) begin
            r_rdata <= w_accept ? w_acc_rdata : r_lat_rdata;
            r_oor   <= w_accept ? ~w_in_range : r_lat_oor;
         end else begin
            r_oor <= 1'b0;
         end
      end
   end

   assign w_push_entry = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00}, data: w_merged};

   dm_trace_fifo #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (TRACE_W)
   ) u_trace_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (trace_ready),
      .o_data  (w_head_bits),
      .o_valid (trace_valid),
      .o_ovf   (trace_ovf)
   );

   assign w_head       = w_head_bits;
   assign trace_pc     = w_head.pc;
   assign trace_addr   = w_head.addr;
   assign trace_data   = w_head.data;
   assign req_ready    = r_req_ready;
   assign resp_valid   = r_resp_valid;
   assign m_data_rdata = r_rdata;
   assign oor          = r_oor;

endmodule

// File: tb/tb_dm_wait_ram.sv
// Self-checking bench for dm_wait_ram: one instance with no wait states and
// one with three, driven by directed and random requests against a
// word-array / queue reference model.
module tb_dm_wait_ram;

   localparam int unsigned WORDS = 4096;
   localparam int unsigned TDEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] addr [2];
   logic [3:0]  be [2];
   logic [31:0] wdata [2];
   logic [31:0] pc [2];
   logic        resp_valid [2];
   logic [31:0] rdata [2];
   logic        oor [2];
   logic        tvalid [2];
   logic        tready [2];
   logic [31:0] tpc [2];
   logic [31:0] taddr [2];
   logic [31:0] tdata [2];
   logic        tovf [2];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   bit [31:0]   mdl [2][WORDS];
   logic [95:0] tq0 [$];
   logic [95:0] tq1 [$];
   bit          movf [2];

   dm_wait_ram #(.WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .m_data_addr(addr[0]), .m_data_byteen(be[0]), .m_data_wdata(wdata[0]), .m_inst_addr(pc[0]),
      .resp_valid(resp_valid[0]), .m_data_rdata(rdata[0]), .oor(oor[0]),
      .trace_valid(tvalid[0]), .trace_ready(tready[0]), .trace_pc(tpc[0]),
      .trace_addr(taddr[0]), .trace_data(tdata[0]), .trace_ovf(tovf[0]));

   dm_wait_ram #(.WAIT_CYCLES(3)) u_dut_w3 (
      .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .m_data_addr(addr[1]), .m_data_byteen(be[1]), .m_data_wdata(wdata[1]), .m_inst_addr(pc[1]),
      .resp_valid(resp_valid[1]), .m_data_rdata(rdata[1]), .oor(oor[1]),
      .trace_valid(tvalid[1]), .trace_ready(tready[1]), .trace_pc(tpc[1]),
      .trace_addr(taddr[1]), .trace_data(tdata[1]), .trace_ovf(tovf[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int waits_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   function automatic int tq_size(input int k);
      return (k == 0) ? tq0.size() : tq1.size();
   endfunction

   // Model of a push: entries beyond capacity are lost and flagged.
   function automatic void tq_push(input int k, input logic [95:0] e);
      if (tq_size(k) >= int'(TDEPTH)) movf[k] = 1'b1;
      else if (k == 0) tq0.push_back(e);
      else tq1.push_back(e);
   endfunction

   function automatic logic [95:0] tq_pop(input int k);
      return (k == 0) ? tq0.pop_front() : tq1.pop_front();
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] b);
      logic [31:0] mask;
      mask = 32'd0;
      for (int i = 0; i < 4; i++) if (b[i]) mask = mask | (32'hFF << (8 * i));
      return (o & ~mask) | (w & mask);
   endfunction

   task automatic wait_ready(input int k);
      int n;
      n = 0;
      while (!req_ready[k] && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", req_ready[k], 1'b1);
   endtask

   // One request, checked for latency, handshake, data, oor and trace side effects.
   task automatic do_req(input int k, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] w, input logic [31:0] p);
      logic [31:0] rel;
      logic [31:0] old;
      logic [31:0] mrg;
      logic [31:0] exp_rd;
      bit          inr;
      int          off;
      int          lat;
      bit          rdy_low;
      wait_ready(k);
      req_valid[k] = 1'b1; addr[k] = a; be[k] = b; wdata[k] = w; pc[k] = p;
      rel = a;
      inr = (rel < 32'h0000_4000);
      off = int'(rel / 4) % int'(WORDS);
      old = inr ? mdl[k][off] : 32'd0;
      mrg = ref_merge(old, w, b);
      exp_rd = (b == 4'd0) ? old : mrg;
      if (b != 4'd0 && inr) begin
         mdl[k][off] = mrg;
         tq_push(k, {p, a & ~32'd3, mrg});
      end
      @(negedge clk);
      lat = 1;
      rdy_low = 1'b1;
      while (!resp_valid[k] && lat < 30) begin
         rdy_low = rdy_low & !req_ready[k];
         req_valid[k] = 1'($urandom_range(0, 1));
         addr[k] = $urandom; be[k] = 4'($urandom); wdata[k] = $urandom;
         @(negedge clk);
         lat++;
      end
      rdy_low = rdy_low & !req_ready[k];
      req_valid[k] = 1'b0;
      check("latency", lat, waits_of(k) + 1);
      check("ready_low_busy", rdy_low, 1'b1);
      check("oor", oor[k], !inr);
      if (inr || b == 4'd0) check("rdata", rdata[k], exp_rd);
      @(negedge clk);
      check("resp_one_cycle", resp_valid[k], 1'b0);
      check("oor_low_idle", oor[k], 1'b0);
      check("ready_back", req_ready[k], 1'b1);
      check("trace_valid", tvalid[k], tq_size(k) > 0);
      check("trace_ovf", tovf[k], movf[k]);
   endtask

   task automatic pop_chk(input int k);
      logic [95:0] e;
      e = tq_pop(k);
      check("tr_valid", tvalid[k], 1'b1);
      check("tr_pc", tpc[k], e[95:64]);
      check("tr_addr", taddr[k], e[63:32]);
      check("tr_data", tdata[k], e[31:0]);
      tready[k] = 1'b1;
      @(negedge clk);
      tready[k] = 1'b0;
   endtask

   task automatic drain(input int k);
      while (tq_size(k) > 0) pop_chk(k);
      check("tr_empty", tvalid[k], 1'b0);
   endtask

   // Counts edges from reset release until req_ready rises.
   task automatic clear_len(input int k, output int cnt);
      cnt = 0;
      while (cnt < 5000) begin
         @(negedge clk);
         cnt++;
         if (req_ready[k]) break;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1;
      bit d0, d1, seen;
      logic [31:0] a, w, p;
      logic [3:0]  b;
      int k;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; addr[i] = '0; be[i] = '0;
         wdata[i] = '0; pc[i] = '0; tready[i] = 1'b0; movf[i] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_ready", req_ready[i], 1'b0);
         check("rst_resp", resp_valid[i], 1'b0);
         check("rst_oor", oor[i], 1'b0);
         check("rst_rdata", rdata[i], 32'd0);
         check("rst_tvalid", tvalid[i], 1'b0);
         check("rst_tovf", tovf[i], 1'b0);
      end
      rst[0] = 1'b0; rst[1] = 1'b0;
      c0 = 0; c1 = 0; d0 = 1'b0; d1 = 1'b0;
      for (int n = 1; n <= 5000 && !(d0 && d1); n++) begin
         @(negedge clk);
         if (!d0 && req_ready[0]) begin d0 = 1'b1; c0 = n; end
         if (!d1 && req_ready[1]) begin d1 = 1'b1; c1 = n; end
      end
      check("clear_len_w0", c0, WORDS);
      check("clear_len_w3", c1, WORDS);

      // Basic read/write with no wait states.
      do_req(0, 32'h10, 4'b0000, 32'h0, 32'h2000);
      do_req(0, 32'h4, 4'b1111, 32'hDEADBEEF, 32'h3000);
      drain(0);
      do_req(0, 32'h4, 4'b0000, 32'h0, 32'h3004);

      // Partial writes and ignored low address bits.
      do_req(0, 32'h8, 4'b1111, 32'h11223344, 32'h3010);
      do_req(0, 32'h8, 4'b0101, 32'hAABBCCDD, 32'h3014);
      check("partial_model", mdl[0][2], 32'h11BB33DD);
      do_req(0, 32'hA, 4'b0010, 32'h0000EE00, 32'h3018);
      drain(0);
      do_req(0, 32'h8, 4'b0000, 32'h0, 32'h301C);

      // Out of range write and read of the unaffected word 0.
      do_req(0, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h3020);
      drain(0);
      do_req(0, 32'h4000, 4'b1111, 32'h12345678, 32'h3024);
      do_req(0, 32'h0, 4'b0000, 32'h0, 32'h3028);
      do_req(0, 32'hFFFF_FFF0, 4'b0000, 32'h0, 32'h302C);

      // Three wait states.
      do_req(1, 32'h0, 4'b0000, 32'h0, 32'h4000);
      do_req(1, 32'h3FFC, 4'b1001, 32'h87654321, 32'h4004);
      drain(1);
      do_req(1, 32'h3FFC, 4'b0000, 32'h0, 32'h4008);

      // Trace overflow: nine writes with no pops.
      for (int i = 0; i < 9; i++) do_req(1, 32'h100 + 32'(4 * i), 4'b1111, $urandom, 32'h5000 + 32'(4 * i));
      check("ovf_set", tovf[1], 1'b1);
      drain(1);

      // Random traffic on both instances.
      for (int i = 0; i < 120; i++) begin
         k = int'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0: begin a = $urandom; if (a < 32'h4000) a = a | 32'h4000; end
            1: a = 32'h3FFC | 32'($urandom_range(0, 3));
            default: a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
         endcase
         b = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         w = $urandom; p = $urandom;
         do_req(k, a, b, w, p);
         if (tq_size(k) >= 6) drain(k);
      end
      drain(0);
      drain(1);

      // Reset during WAIT: no response, overflow and FIFO cleared, clear restarts.
      wait_ready(1);
      req_valid[1] = 1'b1; addr[1] = 32'h20; be[1] = 4'b1111; wdata[1] = 32'h5555AAAA; pc[1] = 32'h6000;
      @(negedge clk);
      req_valid[1] = 1'b0;
      rst[1] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid[1] !== 1'b0) seen = 1'b1;
      end
      check("rst_wait_no_resp", seen, 1'b0);
      check("rst_wait_ovf", tovf[1], 1'b0);
      check("rst_wait_tvalid", tvalid[1], 1'b0);
      check("rst_wait_ready", req_ready[1], 1'b0);
      rst[1] = 1'b0;
      for (int i = 0; i < int'(WORDS); i++) mdl[1][i] = 32'd0;
      tq1.delete();
      movf[1] = 1'b0;
      clear_len(1, c1);
      check("reclear_len", c1, WORDS);
      do_req(1, 32'h20, 4'b0000, 32'h0, 32'h6004);
      check("final_ovf_w0", tovf[0], 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_wait_ram.md
Name: dm_wait_ram

Overview:
Parametrised word-organised data memory for the P7 CPU's data-side bus.
- Byte-enable write merge (read-modify-write of the target word).
- Configurable wait states, giving the CPU a stall handshake.
- Hardware clear sequence after reset.
- Write-trace FIFO the bench drains to print "@pc: *addr <= data" lines.
- Sits between the CPU's m_data_* port and the testbench/bridge; replaces the array-based data memory.

Parameters:
ADDR_W, 12, word-index bits; depth = 2**ADDR_W words (4096).
BASE_ADDR, 32'h0000_0000, byte address of word 0.
WAIT_CYCLES, 0, extra cycles between request acceptance and response (0..15).
TRACE_DEPTH, 8, write-trace FIFO entries (power of two, >=2).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  CPU presents a request
req_ready  out  1  request accepted this cycle when req_valid && req_ready
m_data_addr  in  32  byte address; bits [1:0] ignored
m_data_byteen  in  4  byte enables; 4'b0000 = read
m_data_wdata  in  32  write data, byte lanes aligned to byteen
m_inst_addr  in  32  PC of the issuing instruction, traced only
resp_valid  out  1  one-cycle pulse: request complete
m_data_rdata  out  32  read word, valid when resp_valid
oor  out  1  one-cycle pulse with resp_valid if address was out of range
trace_valid  out  1  trace FIFO non-empty
trace_ready  in  1  bench pops the head entry
trace_pc  out  32  head entry: m_inst_addr
trace_addr  out  32  head entry: word-aligned address
trace_data  out  32  head entry: merged word written
trace_ovf  out  1  sticky: a trace push was dropped because the FIFO was full

Behaviour:
- Reset is synchronous, active-high, on clk. On the first edge with reset=1:
  - FSM enters CLEAR; the clear index is 0.
  - Outputs: req_ready=0, resp_valid=0, oor=0, m_data_rdata=0, trace_valid=0, trace_ovf=0.
  - The FIFO is emptied.
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Writes 0 to one word per cycle at the clear index, then increments the index.
  - After word 2**ADDR_W-1 is written, goes to IDLE. CLEAR lasts exactly 2**ADDR_W cycles after reset deasserts.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On acceptance:
    - word offset = (m_data_addr - BASE_ADDR) >> 2.
    - in range iff (m_data_addr - BASE_ADDR) < 4*2**ADDR_W, computed unsigned in 32 bits, so addresses below BASE_ADDR wrap and are out of range.
  - Read (byteen=0): latches mem[offset], or 0 if out of range.
  - Write (byteen!=0):
    - merged = old word with each enabled byte lane replaced.
    - merged is committed to memory on the acceptance edge; the latched rdata is merged.
    - A trace entry {m_inst_addr, addr & ~3, merged} is pushed.
    - Out-of-range writes are dropped: no commit, no trace push.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - Down-counter loaded with WAIT_CYCLES-1 on acceptance; req_ready=0.
  - Goes to RESP when the counter reaches 0.
- RESP:
  - resp_valid=1 for exactly one cycle; m_data_rdata and oor are driven from the latched values.
  - Returns to IDLE.
  - Request-to-response latency: WAIT_CYCLES+1 cycles after the acceptance edge.
- m_data_rdata holds its last value outside RESP; oor=0 outside RESP.
- Back-to-back requests: because of the RESP state, the next request is accepted no earlier than the cycle after RESP.
- Trace FIFO:
  - Push happens on the write-acceptance edge; pop happens when trace_valid && trace_ready.
  - Simultaneous push and pop when full is legal, with no drop.
  - Push when full with no pop: entry dropped, trace_ovf set; trace_ovf clears only on reset.
  - The head entry is driven combinationally from the FIFO storage.
- reset asserted mid-WAIT or mid-CLEAR:
  - Aborts the pending response; no resp_valid is issued.
  - Clearing restarts from index 0.
  - A write already committed stays committed until the clear overwrites it.
- req_valid while req_ready=0 is ignored; inputs need not be held.

Decomposition:
- Shared package dm_pkg holds:
  - the state enum {CLEAR, IDLE, WAIT, RESP};
  - the trace-entry struct {pc, addr, data} (96 bits);
  - the byte-merge function merge(old, wdata, byteen).
- One sub-module, dm_trace_fifo: synchronous FIFO parameterised by DEPTH and width 96, with full/empty flags and overflow detection.

Test Plan:
- Reset held 2 cycles, then released:
  - req_ready=0 for exactly 4096 cycles, then 1.
  - A read of 0x0000_0010 returns 0.
- WAIT_CYCLES=0:
  - Write addr 0x4, byteen 4'b1111, wdata 0xDEADBEEF, pc 0x3000 -> resp_valid 1 cycle later.
  - Trace entry {0x3000, 0x4, 0xDEADBEEF}.
  - A read of 0x4 returns 0xDEADBEEF.
- Partial write:
  - Preload 0x11223344 at addr 0x8.
  - Write byteen 4'b0101, wdata 0xAABBCCDD -> memory and trace data 0x11BB33DD.
  - Write to addr 0xA: same word, low bits ignored, trace addr 0x8.
- WAIT_CYCLES=3: read accepted at edge t -> resp_valid exactly at t+4; req_ready low for t+1..t+4.
- Out of range: write addr 0x4000 -> oor=1 with resp_valid; no trace push; a subsequent read of 0x0 returns its old value.
- Trace FIFO:
  - 9 writes with trace_ready=0 (TRACE_DEPTH=8) -> trace_ovf=1, trace_valid=1.
  - Popping yields the first 8 entries in order.
  - Reset mid-WAIT produces no resp_valid and clears trace_ovf.
